// File: rtl/resta_pkg.sv
// Shared types and constants for the subtractor result display path.
package resta_pkg;

    localparam int RES_W = 4;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        LOAD  = 2'd1,
        SHOW  = 2'd2
    } disp_state_t;

    // Active-high segment patterns {g,f,e,d,c,b,a} for digits 0..8.
    localparam logic [6:0] SEG_DIGIT [0:8] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F
    };
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_OFF   = 7'h00;

endpackage

// File: rtl/resta_display_seg7.sv
// Combinational 7-segment decoder; digits above 8 are blanked.
module seg7_decoder
    import resta_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (digit <= 4'd8) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/resta_display.sv
// Sign/magnitude display of a 4-bit two's-complement result on a two-digit
// multiplexed 7-segment display. Define SEG_ACTIVE_LOW_EN for common-anode boards.
module resta_display
    import resta_pkg::*;
#(
    parameter int DIV = 25000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res,
    output logic             res_ready,
    output logic [6:0]       seg,
    output logic [1:0]       an,
    output logic             neg
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = 7'h7F;
    localparam logic [1:0] AN_POL  = 2'b11;
`else
    localparam logic [6:0] SEG_POL = 7'h00;
    localparam logic [1:0] AN_POL  = 2'b00;
`endif

    disp_state_t      state_q, state_d;
    logic [RES_W-1:0] res_q, res_d;
    logic [RES_W-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             res_ready_q, res_ready_d;
    logic [6:0]       mag_seg;
    logic             transfer;

    seg7_decoder u_dec (
        .digit (mag_q),
        .seg   (mag_seg)
    );

    // Handshake: a result is taken on any rising edge where res_valid and
    // res_ready are both high; res_ready is registered and drops for the
    // single LOAD cycle, so a value offered then is simply not taken.
    assign transfer = res_valid && res_ready_q;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        seg_d   = seg_q;
        an_d    = an_q;

        case (state_q)
            BLANK: begin
                if (transfer) begin
                    state_d = LOAD;
                    res_d   = res;
                end
            end
            LOAD: begin
                state_d = SHOW;
                neg_d   = res_q[RES_W-1];
                mag_d   = res_q[RES_W-1] ? (~res_q + 4'd1) : res_q;
                cnt_d   = '0;
                sel_d   = 1'b0;
            end
            SHOW: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d = '0;
                    sel_d = ~sel_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Output registers store the board polarity directly.
                if (sel_q) begin
                    an_d  = 2'b10 ^ AN_POL;
                    seg_d = (neg_q ? SEG_MINUS : SEG_OFF) ^ SEG_POL;
                end else begin
                    an_d  = 2'b01 ^ AN_POL;
                    seg_d = mag_seg ^ SEG_POL;
                end
                if (transfer) begin
                    state_d = LOAD;
                    res_d   = res;
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase

        res_ready_d = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            res_q       <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            seg_q       <= SEG_OFF ^ SEG_POL;
            an_q        <= 2'b00 ^ AN_POL;
            res_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            res_ready_q <= res_ready_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign neg       = neg_q;
    assign res_ready = res_ready_q;

endmodule

// File: tb/tb_resta_display.sv
// Randomized self-checking bench for resta_display; expectations come from
// signed arithmetic on the result and the elapsed cycles since display start.
module tb_resta_display;

    localparam int DIV = 4;

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SM = 7'h7F;
    localparam logic [1:0] AM = 2'b11;
`else
    localparam logic [6:0] SM = 7'h00;
    localparam logic [1:0] AM = 2'b00;
`endif

    // clock / reset
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       res_valid = 1'b0;
    logic [3:0] res = 4'd0;
    logic       res_ready;
    logic [6:0] seg;
    logic [1:0] an;
    logic       neg;

    always #5 clk = ~clk;

    resta_display #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res       (res),
        .res_ready (res_ready),
        .seg       (seg),
        .an        (an),
        .neg       (neg)
    );

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] digit_tbl [0:8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F};
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, {1'b0, seg}, {1'b0, SM});
        check_eq({tag, "_an"}, {6'd0, an}, {6'd0, AM});
        check_eq({tag, "_neg"}, {7'd0, neg}, 8'd0);
        check_eq({tag, "_ready"}, {7'd0, res_ready}, 8'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        res_valid = 1'b0;
        repeat (cycles) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check_eq("post_reset_ready", {7'd0, res_ready}, 8'd1);
        check_eq("post_reset_an", {6'd0, an}, {6'd0, AM});
        check_eq("post_reset_seg", {1'b0, seg}, {1'b0, SM});
    endtask

    // Offer r, optionally offer a second value during LOAD, then watch the
    // display for hold extra cycles after it first lights.
    task automatic transfer(input logic [3:0] r, input bit from_blank,
                            input bit glitch, input int hold);
        int  v;
        int  m;
        bit  n;
        int  slot;
        v = (r > 4'd7) ? int'(r) - 16 : int'(r);
        n = (v < 0);
        m = n ? -v : v;

        check_eq("ready_idle", {7'd0, res_ready}, 8'd1);
        res_valid = 1'b1;
        res       = r;
        step();
        check_eq("ready_load", {7'd0, res_ready}, 8'd0);
        if (glitch) begin
            res_valid = 1'b1;
            res       = 4'($urandom_range(0, 15));
        end else begin
            res_valid = 1'b0;
        end
        step();
        res_valid = 1'b0;
        check_eq("neg", {7'd0, neg}, {7'd0, n});
        if (from_blank) check_eq("an_blank_hold", {6'd0, an}, {6'd0, AM});

        exp_q.delete();
        for (int k = 0; k <= hold; k++) begin
            slot = (k / DIV) % 2;
            exp_q.push_back(slot == 0 ? {1'b0, digit_tbl[m] ^ SM}
                                      : {1'b0, (n ? 7'h40 : 7'h00) ^ SM});
        end
        for (int k = 0; k <= hold; k++) begin
            step();
            slot = (k / DIV) % 2;
            check_eq(slot == 0 ? "an_digit0" : "an_digit1", {6'd0, an},
                     {6'd0, (slot == 0 ? 2'b01 : 2'b10) ^ AM});
            check_eq(slot == 0 ? "seg_digit0" : "seg_digit1", {1'b0, seg}, exp_q.pop_front());
            check_eq("ready_show", {7'd0, res_ready}, 8'd1);
        end
    endtask

    initial begin
        bit first;
        do_reset(3);

        transfer(4'b0010, 1'b1, 1'b0, 9);
        transfer(4'b1110, 1'b0, 1'b0, 9);
        transfer(4'b1111, 1'b0, 1'b0, 2);
        transfer(4'b1000, 1'b0, 1'b0, 5);
        transfer(4'b0000, 1'b0, 1'b0, 5);
        transfer(4'b0101, 1'b0, 1'b1, 3);
        transfer(4'b0111, 1'b0, 1'b0, 6);

        // reset for one cycle while showing
        rst_n = 1'b0;
        step();
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        step();
        check_eq("mid_release_ready", {7'd0, res_ready}, 8'd1);

        first = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_reset($urandom_range(1, 3));
                first = 1'b1;
            end
            transfer(4'($urandom_range(0, 15)), first,
                     1'($urandom_range(0, 1)), $urandom_range(0, 12));
            first = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
